// File: rtl/moody_pkg.sv
// Shared definitions for the moody-mimosa emotion model.
// Holds default datapath sizing for the neurotransmitter channel bank,
// the bank FSM state encoding, and the stimulus bit positions that the
// bank and the emotion/sleep/illness regulators agree on.
package moody_pkg;

  // Default level datapath sizing.
  localparam int DEF_LEVEL_W  = 7;
  localparam int DEF_STEP     = 4;
  localparam int DEF_BASELINE = 32;

  // Channel-bank sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } bank_state_e;

  // Stimulus vector bit positions.
  localparam int unsigned TICKLE = 0;
  localparam int unsigned PET    = 1;
  localparam int unsigned FEED   = 2;
  localparam int unsigned PLAY   = 3;
  localparam int unsigned PRAISE = 4;
  localparam int unsigned MUSIC  = 5;
  localparam int unsigned LIGHT  = 6;
  localparam int unsigned WATER  = 7;
  localparam int unsigned POKE   = 8;
  localparam int unsigned SCOLD  = 9;
  localparam int unsigned NOISE  = 10;
  localparam int unsigned DARK   = 11;
  localparam int unsigned COLD   = 12;
  localparam int unsigned HUNGER = 13;
  localparam int unsigned ILL    = 14;

endpackage

// File: rtl/neuro_level_update.sv
// Combinational next-level computation for one neurotransmitter channel.
// Ports:
//   level_i      current channel level
//   stim_i       latched stimulus vector
//   up_mask_i    stimulus bits that raise the level
//   down_mask_i  stimulus bits that lower the level
//   next_level_o level after decay or step-and-clamp
module neuro_level_update #(
  parameter int LEVEL_W  = 7,
  parameter int STIM_W   = 16,
  parameter int STEP     = 4,
  parameter int BASELINE = 32
) (
  input  logic [LEVEL_W-1:0] level_i,
  input  logic [STIM_W-1:0]  stim_i,
  input  logic [STIM_W-1:0]  up_mask_i,
  input  logic [STIM_W-1:0]  down_mask_i,
  output logic [LEVEL_W-1:0] next_level_o
);

  localparam int CNT_W = $clog2(STIM_W + 1);
  // Wide enough that level + STEP*STIM_W and 0 - STEP*STIM_W both fit signed.
  localparam int SUM_W = LEVEL_W + $clog2(STEP * STIM_W + 1) + 1;
  localparam logic signed [SUM_W-1:0] STEP_S = SUM_W'(STEP);
  localparam logic signed [SUM_W-1:0] MAX_S  = SUM_W'((1 << LEVEL_W) - 1);
  localparam logic [LEVEL_W-1:0]      BASE_L = LEVEL_W'(BASELINE);

  function automatic logic [CNT_W-1:0] popcount(input logic [STIM_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < STIM_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

  logic [CNT_W-1:0]        up_cnt_s;
  logic [CNT_W-1:0]        dn_cnt_s;
  logic signed [SUM_W-1:0] sum_s;

  // Popcounts, signed step sum, then either decay or clamp.
  always_comb begin
    up_cnt_s     = popcount(stim_i & up_mask_i);
    dn_cnt_s     = popcount(stim_i & down_mask_i);
    sum_s        = $signed(SUM_W'(level_i))
                 + $signed(SUM_W'(up_cnt_s)) * STEP_S
                 - $signed(SUM_W'(dn_cnt_s)) * STEP_S;
    next_level_o = level_i;
    if ((up_cnt_s == '0) && (dn_cnt_s == '0)) begin
      // Unstimulated: drift one count toward the baseline.
      if (level_i > BASE_L) begin
        next_level_o = level_i - LEVEL_W'(1);
      end else if (level_i < BASE_L) begin
        next_level_o = level_i + LEVEL_W'(1);
      end else begin
        next_level_o = level_i;
      end
    end else if (sum_s[SUM_W-1]) begin
      next_level_o = '0;
    end else if (sum_s > MAX_S) begin
      next_level_o = {LEVEL_W{1'b1}};
    end else begin
      next_level_o = sum_s[LEVEL_W-1:0];
    end
  end

endmodule

// File: rtl/neuro_channel_bank.sv
// Time-multiplexed bank of saturating neurotransmitter levels.
// A tick latches the stimulus vector, then one channel per clock is
// rewritten through a single shared update unit; done pulses once the
// last channel has been written.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   tick, stimuli       update request and stimulus vector (latched on accept)
//   cfg_valid/ready     mask write handshake (ready only while idle)
//   cfg_ch, cfg_sel     target channel, 0 = up mask / 1 = down mask
//   cfg_mask            mask value
//   level               packed levels, channel k at [k*LEVEL_W +: LEVEL_W]
//   busy, done          sequencing status
//   overrun             sticky flag: tick seen while busy
module neuro_channel_bank
  import moody_pkg::*;
#(
  parameter int  NUM_CH   = 5,
  parameter int  LEVEL_W  = DEF_LEVEL_W,
  parameter int  STIM_W   = 16,
  parameter int  STEP     = DEF_STEP,
  parameter int  BASELINE = DEF_BASELINE,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic [STIM_W-1:0]         stimuli,
  input  logic                      cfg_valid,
  output logic                      cfg_ready,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic                      cfg_sel,
  input  logic [STIM_W-1:0]         cfg_mask,
  output logic [NUM_CH*LEVEL_W-1:0] level,
  output logic                      busy,
  output logic                      done,
  output logic                      overrun
);

  localparam logic [CH_W-1:0]    LAST_IDX = CH_W'(NUM_CH - 1);
  localparam logic [LEVEL_W-1:0] BASE_L   = LEVEL_W'(BASELINE);

  bank_state_e         state_q, state_d;
  logic [CH_W-1:0]     idx_q, idx_d;
  logic [STIM_W-1:0]   stim_q;
  logic [LEVEL_W-1:0]  level_q   [NUM_CH];
  logic [STIM_W-1:0]   up_mask_q [NUM_CH];
  logic [STIM_W-1:0]   dn_mask_q [NUM_CH];
  logic                busy_q, done_q, cfg_ready_q, overrun_q;
  logic                tick_accept_s, cfg_fire_s, cfg_ch_ok_s;
  logic [LEVEL_W-1:0]  next_level_s;

  assign tick_accept_s = tick && (state_q == ST_IDLE);
  assign cfg_fire_s    = cfg_valid && cfg_ready_q;
  // Extra bit so NUM_CH itself is representable when NUM_CH is a power of two.
  assign cfg_ch_ok_s   = ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));

  neuro_level_update #(
    .LEVEL_W (LEVEL_W),
    .STIM_W  (STIM_W),
    .STEP    (STEP),
    .BASELINE(BASELINE)
  ) u_update (
    .level_i     (level_q[idx_q]),
    .stim_i      (stim_q),
    .up_mask_i   (up_mask_q[idx_q]),
    .down_mask_i (dn_mask_q[idx_q]),
    .next_level_o(next_level_s)
  );

  // Next-state and channel index sequencing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (tick) begin
          state_d = ST_UPDATE;
          idx_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_UPDATE: begin
        if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + CH_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // State register plus status outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      cfg_ready_q <= (state_d == ST_IDLE);
      // Tick while busy is dropped; only the flag records it.
      if (tick && (state_q != ST_IDLE)) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Stimulus latch, mask writes and per-channel level writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      stim_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        level_q[k]   <= BASE_L;
        up_mask_q[k] <= '0;
        dn_mask_q[k] <= '0;
      end
    end else begin
      if (tick_accept_s) begin
        stim_q <= stimuli;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        // Out-of-range channel writes complete the handshake but land nowhere.
        if (cfg_fire_s && cfg_ch_ok_s && (cfg_ch == CH_W'(k))) begin
          if (cfg_sel) begin
            dn_mask_q[k] <= cfg_mask;
          end else begin
            up_mask_q[k] <= cfg_mask;
          end
        end
        if ((state_q == ST_UPDATE) && (idx_q == CH_W'(k))) begin
          level_q[k] <= next_level_s;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_level_out
    assign level[g*LEVEL_W +: LEVEL_W] = level_q[g];
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_ready = cfg_ready_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_neuro_channel_bank.sv
// Self-checking bench for neuro_channel_bank: directed table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_neuro_channel_bank;

  localparam int NCH  = 5;
  localparam int LW   = 7;
  localparam int SW   = 16;
  localparam int CHW  = 3;
  localparam int BASE = 32;
  localparam int STP  = 4;
  localparam int LMAX = 127;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, tick, cfg_valid, cfg_sel;
  logic [SW-1:0]     stimuli, cfg_mask;
  logic [CHW-1:0]    cfg_ch;
  logic              cfg_ready, busy, done, overrun;
  logic [NCH*LW-1:0] level;

  neuro_channel_bank #(
    .NUM_CH(NCH), .LEVEL_W(LW), .STIM_W(SW), .STEP(STP), .BASELINE(BASE)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .stimuli(stimuli),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
    .cfg_sel(cfg_sel), .cfg_mask(cfg_mask), .level(level),
    .busy(busy), .done(done), .overrun(overrun)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;

  // Reference model state.
  int            m_lvl [NCH];
  logic [SW-1:0] m_up  [NCH];
  logic [SW-1:0] m_dn  [NCH];

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit            cfg_en;
    bit            tick_en;
    bit            same_edge;
    int            ch;
    bit            sel;
    logic [SW-1:0] mask;
    logic [SW-1:0] stim;
    logic [NCH*LW-1:0] exp;
  } vec_t;

  vec_t tbl [12];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int lvl(input int k);
    return int'(level[k*LW +: LW]);
  endfunction

  function automatic logic [NCH*LW-1:0] pack5(input int a, input int b, input int c,
                                              input int d, input int e);
    return {7'(e), 7'(d), 7'(c), 7'(b), 7'(a)};
  endfunction

  // Behavioural rule: decay one toward baseline when unstimulated,
  // otherwise add STEP per up bit, subtract STEP per down bit, saturate.
  function automatic int model_next(input int lv, input logic [SW-1:0] s,
                                    input logic [SW-1:0] um, input logic [SW-1:0] dm);
    int u, d, n;
    u = $countones(s & um);
    d = $countones(s & dm);
    if (u == 0 && d == 0) begin
      if (lv > BASE) return lv - 1;
      if (lv < BASE) return lv + 1;
      return lv;
    end
    n = lv + STP * u - STP * d;
    if (n < 0) n = 0;
    if (n > LMAX) n = LMAX;
    return n;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NCH; k++) begin
      m_lvl[k] = BASE;
      m_up[k]  = '0;
      m_dn[k]  = '0;
    end
  endtask

  task automatic model_cfg(input int ch, input bit sel, input logic [SW-1:0] mask);
    if (ch < NCH) begin
      if (sel) m_dn[ch] = mask;
      else     m_up[ch] = mask;
    end
  endtask

  task automatic do_cfg(input int ch, input bit sel, input logic [SW-1:0] mask);
    bit acc;
    acc = 1'b0;
    cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_sel = sel; cfg_mask = mask;
    for (int n = 0; n < 40 && !acc; n++) begin
      acc = cfg_ready;
      cyc();
    end
    cfg_valid = 1'b0;
    chk("cfg_accept", int'(acc), 1);
    if (acc) model_cfg(ch, sel, mask);
  endtask

  // Full tick with per-edge checks of the one-channel-per-clock sequence.
  task automatic do_tick(input logic [SW-1:0] stim, input bit with_cfg, input int ch,
                         input bit sel, input logic [SW-1:0] mask);
    int expv [NCH];
    int oldv [NCH];
    bit rdy;
    rdy = 1'b0;
    for (int n = 0; n < 40 && !rdy; n++) begin
      rdy = cfg_ready;
      if (!rdy) cyc();
    end
    chk("tick_idle_wait", int'(rdy), 1);
    tick = 1'b1; stimuli = stim;
    if (with_cfg) begin
      cfg_valid = 1'b1; cfg_ch = CHW'(ch); cfg_sel = sel; cfg_mask = mask;
    end
    cyc();
    tick = 1'b0; cfg_valid = 1'b0;
    stimuli = ~stim;  // must have been latched at the accept edge
    if (with_cfg) model_cfg(ch, sel, mask);
    for (int k = 0; k < NCH; k++) begin
      oldv[k] = m_lvl[k];
      expv[k] = model_next(m_lvl[k], stim, m_up[k], m_dn[k]);
    end
    chk("busy_E0", int'(busy), 1);
    chk("done_E0", int'(done), 0);
    chk("ready_E0", int'(cfg_ready), 0);
    for (int k = 0; k < NCH; k++) begin
      cyc();
      chk($sformatf("lvl_ch%0d_at_E%0d", k, k + 1), lvl(k), expv[k]);
      if (k + 1 < NCH) chk($sformatf("untouched_ch%0d_at_E%0d", k + 1, k + 1), lvl(k + 1), oldv[k + 1]);
      chk($sformatf("done_at_E%0d", k + 1), int'(done), (k == NCH - 1) ? 1 : 0);
      chk($sformatf("busy_at_E%0d", k + 1), int'(busy), 1);
    end
    cyc();
    chk("done_end", int'(done), 0);
    chk("busy_end", int'(busy), 0);
    chk("ready_end", int'(cfg_ready), 1);
    for (int k = 0; k < NCH; k++) m_lvl[k] = expv[k];
  endtask

  initial begin
    int dc, v0;
    int expv [NCH];
    rst = 1'b1; tick = 1'b0; stimuli = '0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_sel = 1'b0; cfg_mask = '0;
    model_reset();
    repeat (3) cyc();
    rst = 1'b0;
    cyc();

    // Reset state.
    for (int k = 0; k < NCH; k++) chk($sformatf("reset_lvl_ch%0d", k), lvl(k), BASE);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_ready", int'(cfg_ready), 1);

    // Directed table: {cfg_en, tick_en, same_edge, ch, sel, mask, stim, expected levels}.
    tbl[0]  = '{1, 1, 0, 0, 0, 16'h0003, 16'h0003, pack5(40, 32, 32, 32, 32)};
    tbl[1]  = '{0, 1, 0, 0, 0, 16'h0000, 16'h0000, pack5(39, 32, 32, 32, 32)};
    tbl[2]  = '{0, 1, 0, 0, 0, 16'h0000, 16'h0000, pack5(38, 32, 32, 32, 32)};
    tbl[3]  = '{0, 1, 0, 0, 0, 16'h0000, 16'h0000, pack5(37, 32, 32, 32, 32)};
    tbl[4]  = '{1, 0, 0, 1, 0, 16'hFFFF, 16'h0000, pack5(37, 32, 32, 32, 32)};
    tbl[5]  = '{1, 1, 0, 2, 1, 16'hFFFF, 16'hFFFF, pack5(45, 96, 0, 32, 32)};
    tbl[6]  = '{0, 1, 0, 0, 0, 16'h0000, 16'hFFFF, pack5(53, 127, 0, 32, 32)};
    tbl[7]  = '{0, 1, 0, 0, 0, 16'h0000, 16'h0000, pack5(52, 126, 1, 32, 32)};
    tbl[8]  = '{1, 1, 0, 7, 0, 16'hFFFF, 16'h0004, pack5(51, 127, 0, 32, 32)};
    tbl[9]  = '{1, 0, 0, 3, 0, 16'h00F0, 16'h0000, pack5(51, 127, 0, 32, 32)};
    tbl[10] = '{1, 1, 0, 3, 1, 16'h000F, 16'h0031, pack5(55, 127, 0, 36, 32)};
    tbl[11] = '{1, 1, 1, 4, 0, 16'h8000, 16'h8000, pack5(54, 127, 0, 35, 36)};

    for (int i = 0; i < 12; i++) begin
      if (tbl[i].cfg_en && !tbl[i].same_edge) do_cfg(tbl[i].ch, tbl[i].sel, tbl[i].mask);
      if (tbl[i].tick_en)
        do_tick(tbl[i].stim, tbl[i].same_edge, tbl[i].ch, tbl[i].sel, tbl[i].mask);
      for (int k = 0; k < NCH; k++)
        chk($sformatf("tbl%0d_ch%0d", i, k), lvl(k), int'(tbl[i].exp[k*LW +: LW]));
    end

    // Tick and config during UPDATE: overrun, no restart, write lands once idle.
    dc = done_cnt;
    stimuli = 16'h0003; tick = 1'b1;
    cyc();
    tick = 1'b0;
    for (int k = 0; k < NCH; k++) expv[k] = model_next(m_lvl[k], 16'h0003, m_up[k], m_dn[k]);
    chk("ovr_clear_before", int'(overrun), 0);
    cyc(); cyc();
    tick = 1'b1; cfg_valid = 1'b1; cfg_ch = 3'd0; cfg_sel = 1'b1; cfg_mask = 16'h0001;
    chk("ovr_ready_busy", int'(cfg_ready), 0);
    cyc();
    tick = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    chk("ovr_ready_still_low", int'(cfg_ready), 0);
    cyc(); cyc();
    chk("ovr_done_E5", int'(done), 1);
    cyc();
    chk("ovr_done_E6", int'(done), 0);
    chk("ovr_busy_E6", int'(busy), 0);
    chk("ovr_ready_E6", int'(cfg_ready), 1);
    cyc();
    cfg_valid = 1'b0;
    model_cfg(0, 1'b1, 16'h0001);
    chk("ovr_no_restart", int'(busy), 0);
    for (int k = 0; k < NCH; k++) begin
      chk($sformatf("ovr_lvl_ch%0d", k), lvl(k), expv[k]);
      m_lvl[k] = expv[k];
    end
    repeat (6) cyc();
    chk("ovr_done_pulses", done_cnt - dc, 1);
    chk("ovr_sticky", int'(overrun), 1);
    chk("ovr_idle", int'(busy), 0);

    // The held write must be in force: one up and one down bit cancel on ch0.
    v0 = lvl(0);
    do_tick(16'h0001, 1'b0, 0, 1'b0, 16'h0000);
    chk("held_write_cancel_ch0", lvl(0), v0);
    chk("overrun_still_set", int'(overrun), 1);

    // Reset in the middle of an update.
    while (!cfg_ready) cyc();
    stimuli = 16'hFFFF; tick = 1'b1;
    cyc();
    tick = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    dc = done_cnt;
    cyc();
    rst = 1'b0;
    model_reset();
    for (int k = 0; k < NCH; k++) chk($sformatf("midrst_lvl_ch%0d", k), lvl(k), BASE);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_ready", int'(cfg_ready), 1);
    repeat (8) cyc();
    chk("midrst_no_done", done_cnt - dc, 0);
    // Masks cleared: a full stimulus leaves every channel at baseline.
    do_tick(16'hFFFF, 1'b0, 0, 1'b0, 16'h0000);
    for (int k = 0; k < NCH; k++) chk($sformatf("midrst_mask_ch%0d", k), lvl(k), BASE);

    // Randomized traffic against the model.
    for (int it = 0; it < 40; it++) begin
      int r, ch;
      bit sel;
      logic [SW-1:0] mask, stim;
      r    = $urandom_range(0, 3);
      ch   = $urandom_range(0, 7);
      sel  = 1'($urandom_range(0, 1));
      mask = SW'($urandom & $urandom);
      stim = SW'($urandom & $urandom);
      if (r == 0)      do_cfg(ch, sel, mask);
      else if (r == 1) do_tick(stim, 1'b1, ch, sel, mask);
      else             do_tick(stim, 1'b0, 0, 1'b0, 16'h0000);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) cyc();
    end
    for (int k = 0; k < NCH; k++) chk($sformatf("rand_final_ch%0d", k), lvl(k), m_lvl[k]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
